scaled_video_output_timing: RTL and testbench
=============================================

# scaled_video_output_timing

Display-side stage on `output_clk` that consumes the scaled image from the per-channel output FIFOs of the video processing top. It generates the display raster (hsync/vsync/de), issues FIFO read requests only inside a centred window of size `i_dst_w` x `i_dst_h`, and fills the rest of the frame with a background colour. Each frame it pulses the output-FIFO reset and drives the vsync that starts the next frame's processing.

## Interface
- `H_ACTIVE`, 1920, active pixels per line
- `H_FP`, 88, horizontal front porch
- `H_SYNC`, 44, hsync width
- `H_BP`, 148, horizontal back porch
- `V_ACTIVE`, 1080, active lines
- `V_FP`, 4, vertical front porch
- `V_SYNC`, 5, vsync width
- `V_BP`, 36, vertical back porch
- `HS_POL` / `VS_POL`, 1 / 1, active level of `o_hs` / `o_vs`
- `IMAGE_WIDTH`, 11, width of the `i_dst_w` / `i_dst_h` ports
- `DATA_CHANNEL`, 3, number of 8-bit colour channels
- `BG_COLOR`, 0, background pixel value, width 8*DATA_CHANNEL
- `RST_CYCLES`, 16, length of the FIFO reset pulse in clocks

Ports:
- `output_clk`  in  1  pixel clock
- `sys_rst_n`  in  1  asynchronous, active-low reset
- `i_dst_w`  in  IMAGE_WIDTH  scaled image width
- `i_dst_h`  in  IMAGE_WIDTH  scaled image height
- `o_processed_data_req`  out  1  FIFO read enable
- `i_processed_data`  in  8*DATA_CHANNEL  FIFO read data; valid 1 clock after req
- `o_fifo_o_rst`  out  1  output-FIFO reset pulse
- `o_disp_vsync`  out  1  active-high vsync to the processing controller
- `o_hs`, `o_vs`, `o_de`  out  1 each  display timing
- `o_rgb`  out  8*DATA_CHANNEL  display pixel

## Operation
- Counters:
  - `h_cnt` runs 0..H_TOTAL-1, where H_TOTAL is the sum of the four H parameters.
  - `v_cnt` runs 0..V_TOTAL-1 and increments when `h_cnt` wraps.
  - Active region is h < H_ACTIVE and v < V_ACTIVE.
  - hsync lines: h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync lines: v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
  - Counter width is 12 bits.
- Reset values: `h_cnt`=0, `v_cnt`=V_ACTIVE. The first frame therefore starts in blanking.
- Window geometry:
  - Latched at h=0, v=V_TOTAL-1: w = min(i_dst_w, H_ACTIVE), hgt = min(i_dst_h, V_ACTIVE).
  - x0 = (H_ACTIVE-w)>>1, y0 = (V_ACTIVE-hgt)>>1, using unsigned 12-bit arithmetic.
  - Reset values: w = hgt = 0.
  - A zero w or hgt gives no requests and an all-background frame.
- The window is h in [x0, x0+w) and v in [y0, y0+hgt). Exactly w*hgt reads are issued per frame.
- FSM states:
  - FLUSH: `o_fifo_o_rst`=1; a 5-bit counter counts RST_CYCLES.
    - Entered from reset.
    - Entered from ACTIVE at h=0, v=V_ACTIVE.
    - Goes to BLANK when the count is done.
  - BLANK: waits for the v wrap to 0, then goes to ACTIVE.
  - ACTIVE: requests are permitted only in this state; on reaching v=V_ACTIVE the FSM goes to FLUSH.
- `o_disp_vsync` = 1 on vsync lines regardless of `VS_POL`. These lines always fall after FLUSH completes, because RST_CYCLES < V_FP*H_TOTAL.
- `o_rgb` = `i_processed_data` where the window is set in the aligned pipeline, else BG_COLOR. Outside `o_de`, `o_rgb` = 0.

## Timing
- Pipeline:
  - Cycle t: counters at (h, v).
  - t+1: registered `o_processed_data_req` for position (h, v).
  - t+2: FIFO data arrives; `o_hs`/`o_vs`/`o_de`/`o_rgb` are registered for the same (h, v).
  - Raster latency is 2 clocks; req leads the pixel by exactly 1 clock.
- Reset values of outputs:
  - req=0, `o_de`=0, `o_rgb`=0.
  - `o_hs`=!HS_POL, `o_vs`=!VS_POL.
  - `o_disp_vsync`=0.
  - `o_fifo_o_rst`=0; it goes to 1 on the first clock after reset release.
- Reset asserted mid-line: all state clears asynchronously. No partial request burst may continue after release.
- Dimension changes take effect only at the latch point; a mid-frame change does not alter the current window.
- Simultaneous events:
  - The FIFO reset pulse is never concurrent with req.
  - The window end and the line wrap coinciding (x0+w = H_ACTIVE) must produce no extra request.

## Structure
- A shared package holds:
  - the default 1080p60 timing constants and H_TOTAL/V_TOTAL functions;
  - the FSM state enum {FLUSH, BLANK, ACTIVE}.
- One sub-module, `video_raster_counter`: the h/v counters with sync/active decode. It is reusable by other display paths.

## Test plan
- Reset release with default parameters:
  - `o_fifo_o_rst` high for exactly 16 clocks starting 1 clock after release.
  - Then `o_disp_vsync` high for 5 lines (11000 clocks).
  - The first `o_de` follows 36 lines later.
- dst 960x540:
  - x0=480, y0=270.
  - 518400 reqs per frame.
  - The first req occurs 1 clock before the `o_de` pixel at (480, 270).
  - The BG pixel at (479, 270) and the FIFO data at (480, 270) are correct.
- dst 1920x1080: req equals the delayed `o_de`; 2073600 reqs per frame; no background pixels.
- dst 0x540, and dst 2047x2047 (clamped):
  - 0x540 gives zero reqs and an all-BG frame.
  - 2047x2047 behaves as a full-screen frame.
- Dimension change 960→1280 mid-frame: the current frame keeps 960; the next frame gives x0=320 and 1280*540 reqs.
- `sys_rst_n` pulsed during an active line:
  - Outputs reach reset values immediately.
  - Afterwards the FLUSH/BLANK sequence replays with no req before the first ACTIVE line.

Source files
------------

// File: rtl/scaled_video_output_timing_pkg.sv
// Shared definitions for the display-side output timing path: default
// 1080p60 raster constants, total-length helpers and the FSM state type.
package scaled_video_output_timing_pkg;

  localparam int DEF_H_ACTIVE = 1920;
  localparam int DEF_H_FP     = 88;
  localparam int DEF_H_SYNC   = 44;
  localparam int DEF_H_BP     = 148;
  localparam int DEF_V_ACTIVE = 1080;
  localparam int DEF_V_FP     = 4;
  localparam int DEF_V_SYNC   = 5;
  localparam int DEF_V_BP     = 36;

  // Raster counter width; large enough for any supported total.
  localparam int CNT_W = 12;

  typedef enum logic [1:0] {
    FLUSH,
    BLANK,
    ACTIVE
  } vot_state_e;

  function automatic int h_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int v_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/video_raster_counter.sv
// Free-running h/v raster counters with active/sync region decode.
// Starts in vertical blanking so that a display path has time to settle
// before its first visible line.
module video_raster_counter
  import scaled_video_output_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic             output_clk,
  input  logic             sys_rst_n,
  output logic [CNT_W-1:0] h_cnt_o,
  output logic [CNT_W-1:0] v_cnt_o,
  output logic             active_o,
  output logic             hs_line_o,
  output logic             vs_line_o,
  output logic             frame_last_o
);

  localparam int HT = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int VT = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(HT - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(VT - 1);
  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;

  // Next position: h wraps at end of line, v advances on each h wrap.
  always_comb begin
    h_d = h_q + CNT_W'(1);
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
    end
  end

  // Counter registers; reset lands at the first blanking line.
  always_ff @(posedge output_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_q <= '0;
      v_q <= V_ACT_C;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_cnt_o      = h_q;
  assign v_cnt_o      = v_q;
  assign active_o     = (h_q < H_ACT_C) && (v_q < V_ACT_C);
  assign hs_line_o    = (h_q >= HS_START) && (h_q < HS_END);
  assign vs_line_o    = (v_q >= VS_START) && (v_q < VS_END);
  assign frame_last_o = (h_q == H_LAST) && (v_q == V_LAST);

endmodule

// File: rtl/scaled_video_output_timing.sv
// Display raster generator that pulls a centred scaled image out of the
// output FIFOs, pads the remainder of the frame with a background colour,
// and resets the FIFOs once per frame during vertical blanking.
module scaled_video_output_timing
  import scaled_video_output_timing_pkg::*;
#(
  parameter int                        H_ACTIVE     = DEF_H_ACTIVE,
  parameter int                        H_FP         = DEF_H_FP,
  parameter int                        H_SYNC       = DEF_H_SYNC,
  parameter int                        H_BP         = DEF_H_BP,
  parameter int                        V_ACTIVE     = DEF_V_ACTIVE,
  parameter int                        V_FP         = DEF_V_FP,
  parameter int                        V_SYNC       = DEF_V_SYNC,
  parameter int                        V_BP         = DEF_V_BP,
  parameter logic                      HS_POL       = 1'b1,
  parameter logic                      VS_POL       = 1'b1,
  parameter int                        IMAGE_WIDTH  = 11,
  parameter int                        DATA_CHANNEL = 3,
  parameter logic [8*DATA_CHANNEL-1:0] BG_COLOR     = '0,
  parameter int                        RST_CYCLES   = 16
) (
  input  logic                      output_clk,
  input  logic                      sys_rst_n,
  input  logic [IMAGE_WIDTH-1:0]    i_dst_w,
  input  logic [IMAGE_WIDTH-1:0]    i_dst_h,
  output logic                      o_processed_data_req,
  input  logic [8*DATA_CHANNEL-1:0] i_processed_data,
  output logic                      o_fifo_o_rst,
  output logic                      o_disp_vsync,
  output logic                      o_hs,
  output logic                      o_vs,
  output logic                      o_de,
  output logic [8*DATA_CHANNEL-1:0] o_rgb
);

  localparam int VT = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(VT - 1);
  localparam logic [4:0]       RST_LAST = 5'(RST_CYCLES - 1);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             active, hs_line, vs_line, frame_last;

  video_raster_counter #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_raster (
    .output_clk   (output_clk),
    .sys_rst_n    (sys_rst_n),
    .h_cnt_o      (h_cnt),
    .v_cnt_o      (v_cnt),
    .active_o     (active),
    .hs_line_o    (hs_line),
    .vs_line_o    (vs_line),
    .frame_last_o (frame_last)
  );

  // ---------------- window geometry ----------------
  logic [CNT_W-1:0] w_d, hgt_d, x0_d, y0_d;
  logic [CNT_W-1:0] x0_q, y0_q, x_end_q, y_end_q;
  logic             latch_pt;

  assign latch_pt = (h_cnt == '0) && (v_cnt == V_LAST);

  // Clamp requested size to the raster and centre it.
  always_comb begin
    w_d   = CNT_W'(i_dst_w);
    hgt_d = CNT_W'(i_dst_h);
    if (w_d > H_ACT_C) w_d = H_ACT_C;
    if (hgt_d > V_ACT_C) hgt_d = V_ACT_C;
    x0_d = (H_ACT_C - w_d) >> 1;
    y0_d = (V_ACT_C - hgt_d) >> 1;
  end

  // Window bounds only change at the last blanking line, so a mid-frame
  // size change never disturbs the frame being displayed.
  always_ff @(posedge output_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      x0_q    <= '0;
      y0_q    <= '0;
      x_end_q <= '0;
      y_end_q <= '0;
    end else if (latch_pt) begin
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      x_end_q <= x0_d + w_d;
      y_end_q <= y0_d + hgt_d;
    end
  end

  // ---------------- frame FSM ----------------
  vot_state_e state_q, state_d;
  logic [4:0] flush_cnt_q, flush_cnt_d;

  // Next state: flush FIFOs, wait for frame start, stream the visible part.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      FLUSH: begin
        if (flush_cnt_q == RST_LAST) begin
          state_d     = BLANK;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + 5'd1;
        end
      end
      BLANK: begin
        if (frame_last) state_d = ACTIVE;
      end
      ACTIVE: begin
        if ((h_cnt == '0) && (v_cnt == V_ACT_C)) begin
          state_d     = FLUSH;
          flush_cnt_d = '0;
        end
      end
      default: begin
        state_d     = FLUSH;
        flush_cnt_d = '0;
      end
    endcase
  end

  // State register; reset starts a flush so stale FIFO contents are dropped.
  always_ff @(posedge output_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= FLUSH;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // FIFO reset follows the FLUSH state by one clock.
  logic fifo_rst_q;
  always_ff @(posedge output_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) fifo_rst_q <= 1'b0;
    else            fifo_rst_q <= (state_q == FLUSH);
  end

  // ---------------- output pipeline ----------------
  logic in_win;
  assign in_win = (state_q == ACTIVE) && active &&
                  (h_cnt >= x0_q) && (h_cnt < x_end_q) &&
                  (v_cnt >= y0_q) && (v_cnt < y_end_q);

  logic req_q, de1_q, hs1_q, vs1_q;
  logic win_q, de_q, hs_q, vs_q, disp_vsync_q;

  // Stage 1: read request plus raster flags for the same position.
  always_ff @(posedge output_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      req_q <= 1'b0;
      de1_q <= 1'b0;
      hs1_q <= 1'b0;
      vs1_q <= 1'b0;
    end else begin
      req_q <= in_win;
      de1_q <= active;
      hs1_q <= hs_line;
      vs1_q <= vs_line;
    end
  end

  // Stage 2: display timing aligned with the FIFO data of the request.
  always_ff @(posedge output_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      win_q        <= 1'b0;
      de_q         <= 1'b0;
      hs_q         <= ~HS_POL;
      vs_q         <= ~VS_POL;
      disp_vsync_q <= 1'b0;
    end else begin
      win_q        <= req_q;
      de_q         <= de1_q;
      hs_q         <= hs1_q ^ ~HS_POL;
      vs_q         <= vs1_q ^ ~VS_POL;
      disp_vsync_q <= vs1_q;
    end
  end

  // FIFO data is valid in the clock after the request, which is exactly
  // the clock the pixel is on screen, so it is muxed straight through.
  assign o_rgb = de_q ? (win_q ? i_processed_data : BG_COLOR) : '0;

  assign o_processed_data_req = req_q;
  assign o_fifo_o_rst         = fifo_rst_q;
  assign o_disp_vsync         = disp_vsync_q;
  assign o_hs                 = hs_q;
  assign o_vs                 = vs_q;
  assign o_de                 = de_q;

endmodule

// File: tb/tb_scaled_video_output_timing.sv
// Randomised scoreboard bench on a reduced raster so that many frames fit
// in a short run. A FIFO model answers the read requests from a random data
// table; a positional reference model predicts every output.
module tb_scaled_video_output_timing;

  localparam int HA = 32, HFP = 4, HSW = 4, HBP = 8;
  localparam int VA = 20, VFP = 2, VSW = 2, VBP = 3;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;
  localparam int S = VA * HT;          // linear raster index at reset
  localparam int RSTC = 16;
  localparam logic [23:0] BG = 24'h3c5a96;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] dst_w = '0, dst_h = '0;
  logic        req;
  logic [23:0] pdata = '0;
  logic        fifo_rst, disp_vsync, hs, vs, de;
  logic [23:0] rgb;

  always #5 clk = ~clk;

  scaled_video_output_timing #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
    .HS_POL (1'b1), .VS_POL (1'b1), .IMAGE_WIDTH (11), .DATA_CHANNEL (3),
    .BG_COLOR (BG), .RST_CYCLES (RSTC)
  ) dut (
    .output_clk           (clk),
    .sys_rst_n            (rst_n),
    .i_dst_w              (dst_w),
    .i_dst_h              (dst_h),
    .o_processed_data_req (req),
    .i_processed_data     (pdata),
    .o_fifo_o_rst         (fifo_rst),
    .o_disp_vsync         (disp_vsync),
    .o_hs                 (hs),
    .o_vs                 (vs),
    .o_de                 (de),
    .o_rgb                (rgb)
  );

  logic [23:0] data_mem [1024];
  int ncmp = 0, nfail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    ncmp++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, expv);
    end
  endtask

  // ---------------- FIFO model ----------------
  int rd_idx = 0;
  initial begin
    forever begin
      @(posedge clk);
      if (fifo_rst) rd_idx = 0;
      else if (req) begin
        pdata <= data_mem[rd_idx % 1024];
        rd_idx = rd_idx + 1;
      end
    end
  end

  // ---------------- reference model ----------------
  int cnt = 0;                       // clock edges since reset release
  int mw = 0, mh = 0, mx0 = 0, my0 = 0, widx = 0;
  logic [23:0] exp_q [$];

  function automatic bit in_win(input int p);
    int h, v;
    h = p % HT;
    v = (p / HT) % VT;
    return (h >= mx0) && (h < mx0 + mw) && (v >= my0) && (v < my0 + mh);
  endfunction

  initial begin
    int p, h, v;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        cnt = 0; mw = 0; mh = 0; mx0 = 0; my0 = 0; widx = 0;
        exp_q.delete();
      end else begin
        p = S + cnt;                 // raster position during the cycle just ended
        h = p % HT;
        v = (p / HT) % VT;
        cnt++;
        if (h == 0 && v == VT - 1) begin
          mw  = (int'(dst_w) > HA) ? HA : int'(dst_w);
          mh  = (int'(dst_h) > VA) ? VA : int'(dst_h);
          mx0 = (HA - mw) / 2;
          my0 = (VA - mh) / 2;
          widx = 0;
        end
        if (h < HA && v < VA) begin
          if (in_win(p)) begin
            exp_q.push_back(data_mem[widx % 1024]);
            widx++;
          end else begin
            exp_q.push_back(BG);
          end
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    int c, p, h, v;
    bit e_fifo;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        chk("rst_req", 32'(req), 0);
        chk("rst_de", 32'(de), 0);
        chk("rst_rgb", 32'(rgb), 0);
        chk("rst_hs", 32'(hs), 0);
        chk("rst_vs", 32'(vs), 0);
        chk("rst_dvs", 32'(disp_vsync), 0);
        chk("rst_fifo", 32'(fifo_rst), 0);
      end else begin
        c = cnt;
        chk("req", 32'(req), (c >= 1) ? 32'(in_win(S + c - 1)) : 0);
        e_fifo = (c >= 1 && c <= RSTC) || (c > FRAME && ((c - 2) % FRAME) < RSTC);
        chk("fifo_rst", 32'(fifo_rst), 32'(e_fifo));
        if (c >= 2) begin
          p = S + c - 2;
          h = p % HT;
          v = (p / HT) % VT;
          chk("de", 32'(de), 32'(h < HA && v < VA));
          chk("hs", 32'(hs), 32'(h >= HA + HFP && h < HA + HFP + HSW));
          chk("vs", 32'(vs), 32'(v >= VA + VFP && v < VA + VFP + VSW));
          chk("disp_vsync", 32'(disp_vsync), 32'(v >= VA + VFP && v < VA + VFP + VSW));
        end else begin
          chk("de_pre", 32'(de), 0);
          chk("hs_pre", 32'(hs), 0);
        end
        if (!de) chk("rgb_blank", 32'(rgb), 0);
        else if (exp_q.size() == 0) begin
          ncmp++; nfail++;
          $display("FAIL pixel_underflow t=%0t got=%0h expected=none", $time, rgb);
        end else begin
          chk("pixel", 32'(rgb), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int tw [7] = '{16, 32, 0, 2047, 31, 1, 17};
  int th [7] = '{10, 20, 10, 2047, 19, 1, 3};

  initial begin
    int waited;
    for (int i = 0; i < 1024; i++) data_mem[i] = 24'($urandom);
    rst_n = 1'b0;
    dst_w = 11'd16; dst_h = 11'd10;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      dst_w = 11'(tw[i]);
      dst_h = 11'(th[i]);
      $display("frame dims %0dx%0d", tw[i], th[i]);
      repeat (FRAME) @(negedge clk);
    end
    // random mid-frame size changes
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(150, 1500)) @(negedge clk);
      dst_w = 11'($urandom_range(0, 40));
      dst_h = 11'($urandom_range(0, 25));
      $display("dims change to %0dx%0d", dst_w, dst_h);
    end
    repeat (FRAME) @(negedge clk);
    // reset pulse in the middle of a visible line
    dst_w = 11'd16; dst_h = 11'd10;
    waited = 0;
    while (de !== 1'b1 && waited < 2 * FRAME) begin
      @(negedge clk);
      waited++;
    end
    chk("de_wait", 32'(de), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    $display("reset asserted mid-line");
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * FRAME) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nfail);
    $finish;
  end

endmodule
